cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Run-control sequencer for the microprogrammed CPU.
- Gates the CPU clock-enable that feeds the CAR and datapath registers, so the CPU can be started, single-stepped, halted and aborted.
- Shares the single-port program/data memory between the CPU and an external program loader (UART/debug).
- Sits between the top level, the control unit and the memory.

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 16, memory data width

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  pulse; begin a program run from a cleared CPU
- step  input  1  pulse; execute exactly one instruction
- abort  input  1  force IDLE from any state
- halt_flag  input  1  control unit is executing the HALT microprogram
- car_data  input  8  current microinstruction address from the CAR
- cpu_mem_en  input  1  CPU memory access this cycle
- cpu_we  input  1  CPU write enable
- cpu_addr  input  ADDR_W  CPU address
- cpu_wdata  input  DATA_W  CPU write data
- ld_req  input  1  loader requests one memory access
- ld_we  input  1  loader write enable
- ld_addr  input  ADDR_W  loader address
- ld_wdata  input  DATA_W  loader write data
- ld_ack  output  1  loader access performed this cycle
- mem_en  output  1  memory enable
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- cpu_en  output  1  clock-enable for CAR and CPU registers
- cpu_clr  output  1  one-cycle clear of PC/ACC/CAR
- state  output  3  current state encoding
- run_cycles  output  32  enabled-cycle count (see Optional Feature)

Behaviour:

States and encodings: IDLE=0, CLR=1, RUN=2, STEP=3, HALTED=4, LOAD=5.

Moore outputs, all derived from the state register:
- cpu_en = 1 in RUN and STEP only.
- cpu_clr = 1 in CLR only.
- ld_ack = 1 in LOAD only.

Reset (rst=1 at a clock edge):
- state=IDLE, ret_halted=0, step_seen=0, run_cycles=0.
- All outputs 0.

abort has highest priority after rst: from any state, next state is IDLE; any in-flight loader access is dropped (no ld_ack).

IDLE:
- ld_req=1: go to LOAD, ret_halted=0. ld_req beats start/step in the same cycle; start/step are dropped.
- else start=1: go to CLR.
- else step=1: go to STEP, step_seen=0.

CLR: lasts one cycle, then RUN.

RUN:
- halt_flag=1: go to HALTED. cpu_en is low from the next cycle.
- ld_req is not served; ld_ack stays 0 and the loader holds its request.

STEP:
- step_seen is set when car_data!=0.
- halt_flag=1: go to HALTED (takes priority).
- else step_seen=1 and car_data==0: go to IDLE. The instruction has completed and the CPU is back at FETCH step 0.
- Net effect: a step runs FETCH plus one execute microprogram, then stops at car_data=0x00.

HALTED:
- ld_req=1: go to LOAD, ret_halted=1 (takes priority).
- else start=1: go to CLR (restart from a cleared CPU).
- step is ignored.

LOAD:
- Lasts one cycle, then returns to HALTED if ret_halted else IDLE.
- Read data is valid on the memory read port the cycle after ld_ack.
- Back-to-back loader accesses alternate LOAD/IDLE, i.e. at most one access per 2 cycles.

Memory mux:
- RUN/STEP: mem_en=cpu_mem_en, and mem_we/addr/wdata come from the cpu_* inputs.
- LOAD: mem_en=1, and mem_we/addr/wdata come from the ld_* inputs.
- Other states: mem_en=0, mem_we=0, addr/wdata=0.

Optional Feature:
- Macro: RUN_CTRL_CYCLE_CNT_EN.
- Defined:
  - run_cycles is a 32-bit counter that increments on every cycle with cpu_en=1.
  - Cleared in CLR and on rst; held in all other states.
  - Wraps 0xFFFFFFFF to 0.
- Undefined: run_cycles is tied to 0 and no counter logic is synthesised.

Test Plan:
1. rst for 2 cycles -> state=0, cpu_en=0, mem_en=0, ld_ack=0, run_cycles=0.
2. In IDLE, ld_req=1, ld_we=1, ld_addr=0x10, ld_wdata=0x1234 -> next cycle state=5, ld_ack=1, mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0x1234; following cycle state=0.
3. start pulse -> state CLR for 1 cycle with cpu_clr=1, then RUN with cpu_en=1. Drive halt_flag=1 after 20 RUN cycles -> state=4, cpu_en=0. With RUN_CTRL_CYCLE_CNT_EN defined, run_cycles=20.
4. step pulse in IDLE; drive car_data sequence 0x00,0x01,0x02,0x03,0x07,0x08,0x09,0x0A,0x00 -> cpu_en high through the cycle car_data returns to 0x00, then state=0.
5. In RUN, assert ld_req -> ld_ack stays 0. After halt_flag, LOAD is served in the cycle after entering HALTED, then state returns to 4.
6. Same cycle start=1 and ld_req=1 in IDLE -> LOAD taken, start dropped, state returns to 0. abort mid-RUN -> state=0 next cycle, cpu_en=0.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// Memory-side bundle of the run controller: CPU request, loader request and the
// shared single-port memory. "master" is the run controller, "slave" its environment.
interface cpu_run_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              cpu_mem_en;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;

    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        input  cpu_mem_en, cpu_we, cpu_addr, cpu_wdata,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_ack,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output cpu_mem_en, cpu_we, cpu_addr, cpu_wdata,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: gates the CPU clock-enable and shares memory with the loader.
// Optional enabled-cycle counter is built when RUN_CTRL_CYCLE_CNT_EN is defined.
module cpu_run_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step,
    input  logic        abort,
    input  logic        halt_flag,
    input  logic [7:0]  car_data,
    cpu_run_ctrl_if.master bus,
    output logic        cpu_en,
    output logic        cpu_clr,
    output logic [2:0]  state,
    output logic [31:0] run_cycles
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        RUN    = 3'd2,
        STEP   = 3'd3,
        HALTED = 3'd4,
        LOAD   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              ret_halted, ret_halted_d;
    logic              step_seen, step_seen_d;
    logic              mem_en_mux, mem_we_mux, ld_ack_mux;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ret_halted <= 1'b0;
            step_seen  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_halted <= ret_halted_d;
            step_seen  <= step_seen_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ret_halted_d = ret_halted;
        step_seen_d  = step_seen;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.ld_req) begin
                        state_d      = LOAD;
                        ret_halted_d = 1'b0;
                    end else if (start) begin
                        state_d = CLR;
                    end else if (step) begin
                        state_d     = STEP;
                        step_seen_d = 1'b0;
                    end
                end
                CLR:  state_d = RUN;
                RUN:  if (halt_flag) state_d = HALTED;
                STEP: begin
                    // A step ends when the CAR returns to 0 after having left it.
                    if (car_data != 8'd0) step_seen_d = 1'b1;
                    if (halt_flag)
                        state_d = HALTED;
                    else if (step_seen && car_data == 8'd0)
                        state_d = IDLE;
                end
                HALTED: begin
                    if (bus.ld_req) begin
                        state_d      = LOAD;
                        ret_halted_d = 1'b1;
                    end else if (start) begin
                        state_d = CLR;
                    end
                end
                LOAD:    state_d = ret_halted ? HALTED : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cpu_en     = 1'b0;
        cpu_clr    = 1'b0;
        ld_ack_mux = 1'b0;
        mem_en_mux = 1'b0;
        mem_we_mux = 1'b0;
        addr_mux   = '0;
        wdata_mux  = '0;
        unique case (state_q)
            RUN, STEP: begin
                cpu_en     = 1'b1;
                mem_en_mux = bus.cpu_mem_en;
                mem_we_mux = bus.cpu_we;
                addr_mux   = bus.cpu_addr;
                wdata_mux  = bus.cpu_wdata;
            end
            CLR: cpu_clr = 1'b1;
            LOAD: begin
                ld_ack_mux = 1'b1;
                mem_en_mux = 1'b1;
                mem_we_mux = bus.ld_we;
                addr_mux   = bus.ld_addr;
                wdata_mux  = bus.ld_wdata;
            end
            default: ;
        endcase
    end

    assign bus.ld_ack    = ld_ack_mux;
    assign bus.mem_en    = mem_en_mux;
    assign bus.mem_we    = mem_we_mux;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;
    assign state         = state_q;

`ifdef RUN_CTRL_CYCLE_CNT_EN
    logic [31:0] cycle_cnt;

    // Restarted by CLR so each run reports only its own enabled cycles.
    always_ff @(posedge clk) begin
        if (rst || state_q == CLR)
            cycle_cnt <= '0;
        else if (cpu_en)
            cycle_cnt <= cycle_cnt + 32'd1;
    end

    assign run_cycles = cycle_cnt;
`else
    assign run_cycles = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed test-plan steps followed by random traffic,
// all checked against a behavioural model of the run-control rules.
module tb_cpu_run_ctrl;

    localparam int S_IDLE = 0, S_CLR = 1, S_RUN = 2, S_STEP = 3, S_HALTED = 4, S_LOAD = 5;
`ifdef RUN_CTRL_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, step, abort, halt_flag;
    logic [7:0]  car_data;
    logic        cpu_en, cpu_clr;
    logic [2:0]  state;
    logic [31:0] run_cycles;

    int checks = 0;
    int errors = 0;

    int          m_state;
    bit          m_ret_halted;
    bit          m_seen_nonzero;
    logic [31:0] m_cycles;

    cpu_run_ctrl_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    cpu_run_ctrl #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .step       (step),
        .abort      (abort),
        .halt_flag  (halt_flag),
        .car_data   (car_data),
        .bus        (bus),
        .cpu_en     (cpu_en),
        .cpu_clr    (cpu_clr),
        .state      (state),
        .run_cycles (run_cycles)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        rst = 0; start = 0; step = 0; abort = 0; halt_flag = 0; car_data = 8'h00;
        bus.cpu_mem_en = 0; bus.cpu_we = 0; bus.cpu_addr = 8'h00; bus.cpu_wdata = 16'h0000;
        bus.ld_req = 0; bus.ld_we = 0; bus.ld_addr = 8'h00; bus.ld_wdata = 16'h0000;
    endtask

    // Reference: what one clock edge does, given the mode before the edge and the inputs.
    task automatic model_update();
        int nxt;
        if (rst) begin
            m_state = S_IDLE; m_ret_halted = 0; m_seen_nonzero = 0; m_cycles = 0;
            return;
        end
        if (CNT_EN) begin
            if (m_state == S_CLR) m_cycles = 0;
            else if (m_state == S_RUN || m_state == S_STEP) m_cycles = m_cycles + 1;
        end
        nxt = m_state;
        if (abort) nxt = S_IDLE;
        else if (m_state == S_IDLE) begin
            if (bus.ld_req) begin nxt = S_LOAD; m_ret_halted = 0; end
            else if (start) nxt = S_CLR;
            else if (step) begin nxt = S_STEP; m_seen_nonzero = 0; end
        end else if (m_state == S_CLR) nxt = S_RUN;
        else if (m_state == S_RUN) begin
            if (halt_flag) nxt = S_HALTED;
        end else if (m_state == S_STEP) begin
            if (halt_flag) nxt = S_HALTED;
            else if (m_seen_nonzero && car_data == 0) nxt = S_IDLE;
            if (car_data != 0) m_seen_nonzero = 1;
        end else if (m_state == S_HALTED) begin
            if (bus.ld_req) begin nxt = S_LOAD; m_ret_halted = 1; end
            else if (start) nxt = S_CLR;
        end else if (m_state == S_LOAD) nxt = m_ret_halted ? S_HALTED : S_IDLE;
        m_state = nxt;
    endtask

    task automatic check_output();
        bit cpu_owns, ld_owns;
        cpu_owns = (m_state == S_RUN || m_state == S_STEP);
        ld_owns  = (m_state == S_LOAD);
        check_value("state", 32'(state), 32'(m_state));
        check_value("cpu_en", 32'(cpu_en), 32'(cpu_owns));
        check_value("cpu_clr", 32'(cpu_clr), 32'(m_state == S_CLR));
        check_value("ld_ack", 32'(bus.ld_ack), 32'(ld_owns));
        check_value("mem_en", 32'(bus.mem_en),
                    cpu_owns ? 32'(bus.cpu_mem_en) : 32'(ld_owns));
        check_value("mem_we", 32'(bus.mem_we),
                    cpu_owns ? 32'(bus.cpu_we) : (ld_owns ? 32'(bus.ld_we) : 32'd0));
        check_value("mem_addr", 32'(bus.mem_addr),
                    cpu_owns ? 32'(bus.cpu_addr) : (ld_owns ? 32'(bus.ld_addr) : 32'd0));
        check_value("mem_wdata", 32'(bus.mem_wdata),
                    cpu_owns ? 32'(bus.cpu_wdata) : (ld_owns ? 32'(bus.ld_wdata) : 32'd0));
        check_value("run_cycles", run_cycles, m_cycles);
    endtask

    // Inputs are changed 1 time unit after an edge; one call advances one clock.
    task automatic apply_stimulus();
        @(posedge clk);
        model_update();
        #1;
        check_output();
    endtask

    task automatic randomize_cpu_bus();
        bus.cpu_mem_en = 1'($urandom);
        bus.cpu_we     = 1'($urandom);
        bus.cpu_addr   = 8'($urandom);
        bus.cpu_wdata  = 16'($urandom);
    endtask

    initial begin
        m_state = S_IDLE; m_ret_halted = 0; m_seen_nonzero = 0; m_cycles = 0;
        clear_inputs();
        #1;

        rst = 1;
        apply_stimulus();
        apply_stimulus();
        check_value("reset_state", 32'(state), 32'd0);
        check_value("reset_run_cycles", run_cycles, 32'd0);
        rst = 0;
        apply_stimulus();

        bus.ld_req = 1; bus.ld_we = 1; bus.ld_addr = 8'h10; bus.ld_wdata = 16'h1234;
        apply_stimulus();
        check_value("load_state", 32'(state), 32'd5);
        check_value("load_addr", 32'(bus.mem_addr), 32'h10);
        check_value("load_wdata", 32'(bus.mem_wdata), 32'h1234);
        bus.ld_req = 0;
        apply_stimulus();
        check_value("load_return_idle", 32'(state), 32'd0);

        start = 1;
        apply_stimulus();
        check_value("clr_pulse", 32'(cpu_clr), 32'd1);
        start = 0;
        for (int i = 0; i < 20; i++) begin
            randomize_cpu_bus();
            apply_stimulus();
        end
        halt_flag = 1;
        apply_stimulus();
        halt_flag = 0;
        check_value("halted_state", 32'(state), 32'd4);
        check_value("halted_cpu_en", 32'(cpu_en), 32'd0);
        check_value("run_20_cycles", run_cycles, CNT_EN ? 32'd20 : 32'd0);

        abort = 1;
        apply_stimulus();
        abort = 0;
        step = 1;
        apply_stimulus();
        step = 0;
        begin
            logic [7:0] seq [9] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h00};
            for (int i = 0; i < 9; i++) begin
                car_data = seq[i];
                check_value("step_cpu_en", 32'(cpu_en), 32'd1);
                apply_stimulus();
            end
        end
        car_data = 8'h00;
        check_value("step_done_idle", 32'(state), 32'd0);

        start = 1;
        apply_stimulus();
        start = 0;
        apply_stimulus();
        bus.ld_req = 1; bus.ld_we = 0; bus.ld_addr = 8'h3C; bus.ld_wdata = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus();
            check_value("run_no_ld_ack", 32'(bus.ld_ack), 32'd0);
        end
        halt_flag = 1;
        apply_stimulus();
        halt_flag = 0;
        apply_stimulus();
        check_value("halted_load_served", 32'(bus.ld_ack), 32'd1);
        bus.ld_req = 0;
        apply_stimulus();
        check_value("load_back_to_halted", 32'(state), 32'd4);

        abort = 1;
        apply_stimulus();
        abort = 0;
        start = 1; bus.ld_req = 1;
        apply_stimulus();
        start = 0; bus.ld_req = 0;
        check_value("ld_beats_start", 32'(state), 32'd5);
        apply_stimulus();
        check_value("start_dropped", 32'(state), 32'd0);
        start = 1;
        apply_stimulus();
        start = 0;
        apply_stimulus();
        apply_stimulus();
        abort = 1;
        apply_stimulus();
        abort = 0;
        check_value("abort_idle", 32'(state), 32'd0);
        check_value("abort_cpu_en", 32'(cpu_en), 32'd0);

        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 63) == 0);
            abort       = ($urandom_range(0, 31) == 0);
            start       = ($urandom_range(0, 7) == 0);
            step        = ($urandom_range(0, 7) == 0);
            halt_flag   = ($urandom_range(0, 11) == 0);
            bus.ld_req  = ($urandom_range(0, 5) == 0);
            bus.ld_we   = 1'($urandom);
            bus.ld_addr = 8'($urandom);
            bus.ld_wdata = 16'($urandom);
            car_data    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            randomize_cpu_bus();
            apply_stimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
